// File: rtl/fma_norm_round.sv
`timescale 1ns/1ps
// FMA back end: leading-zero normalise, subnormal handling, RISC-V rounding and IEEE packing.
// Two registered stages with valid/ready on both sides; stage 1 counts zeros, stage 2 shifts/rounds/packs.
module fma_norm_round #(
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_BIAS  = 127,
  parameter int PARM_SUM_W = 76
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic [PARM_SUM_W-1:0]         Sum_i,
  input  logic [PARM_EXP+1:0]           Exp_i,
  input  logic                          Sign_i,
  input  logic                          Sticky_i,
  input  logic [2:0]                    Rnd_mode_i,
  input  logic                          Special_i,
  input  logic [PARM_EXP+PARM_MANT:0]   Special_result_i,
  input  logic                          Invalid_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Fflags_o
);
  localparam int EW   = PARM_EXP + 3;
  localparam int LZW  = $clog2(PARM_SUM_W + 1);
  localparam int GRD  = PARM_SUM_W - PARM_MANT - 2;
  localparam int EMAX = 2 * PARM_BIAS + 1;

  logic                        s1_valid;
  logic [PARM_SUM_W-1:0]       s1_sum;
  logic [LZW-1:0]              s1_lz;
  logic [EW-1:0]               s1_e;
  logic                        s1_sign, s1_sticky, s1_special, s1_invalid;
  logic [2:0]                  s1_rnd;
  logic [PARM_EXP+PARM_MANT:0] s1_spec_res;

  logic                        adv;
  logic [LZW-1:0]              lz;
  logic [EW-1:0]               e_in;

  assign Ready_o = ~s1_valid | ~Valid_o | Ready_i;
  assign adv     = ~Valid_o | Ready_i;

  always_comb begin
    lz = LZW'(PARM_SUM_W);
    for (int i = 0; i < PARM_SUM_W; i++)
      if (Sum_i[i]) lz = LZW'(PARM_SUM_W - 1 - i);
  end

  assign e_in = {{(EW-PARM_EXP-2){Exp_i[PARM_EXP+1]}}, Exp_i} + EW'(1) - {{(EW-LZW){1'b0}}, lz};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_lz       <= '0;
      s1_e        <= '0;
      s1_sign     <= 1'b0;
      s1_sticky   <= 1'b0;
      s1_rnd      <= '0;
      s1_special  <= 1'b0;
      s1_spec_res <= '0;
      s1_invalid  <= 1'b0;
    end else if (Ready_o) begin
      s1_valid <= Valid_i;
      if (Valid_i) begin
        s1_sum      <= Sum_i;
        s1_lz       <= lz;
        s1_e        <= e_in;
        s1_sign     <= Sign_i;
        s1_sticky   <= Sticky_i;
        s1_rnd      <= Rnd_mode_i;
        s1_special  <= Special_i;
        s1_spec_res <= Special_result_i;
        s1_invalid  <= Invalid_i;
      end
    end
  end

  logic                        subn, lost, hidden, guard, stk, rnd_up, nx, uf, ovf, to_inf;
  logic [EW-1:0]               k, rsh_full, exp_pre, exp_fin;
  logic [LZW-1:0]              rsh, lsh;
  logic [PARM_SUM_W-1:0]       sh;
  logic [PARM_MANT-1:0]        frac;
  logic [GRD-1:0]              low;
  logic [EW+PARM_MANT-1:0]     ext;
  logic [PARM_EXP+PARM_MANT:0] res_d;
  logic [4:0]                  flg_d;

  // A zero magnitude takes the subnormal path so it packs with exponent field 0.
  assign subn     = s1_e[EW-1] | (s1_e == '0) | (s1_lz == LZW'(PARM_SUM_W));
  assign k        = s1_e + {{(EW-LZW){1'b0}}, s1_lz} - EW'(1);
  assign rsh_full = '0 - k;
  assign rsh      = (rsh_full > EW'(PARM_SUM_W)) ? LZW'(PARM_SUM_W) : rsh_full[LZW-1:0];
  assign lsh      = subn ? k[LZW-1:0] : s1_lz;

  always_comb begin
    sh   = '0;
    lost = 1'b0;
    if (subn & k[EW-1]) begin
      sh   = s1_sum >> rsh;
      lost = |(s1_sum & ~({PARM_SUM_W{1'b1}} << rsh));
    end else begin
      sh = s1_sum << lsh;
    end
  end

  assign {hidden, frac, guard, low} = sh;
  assign stk = |low | lost | s1_sticky;

  always_comb begin
    case (s1_rnd)
      3'b001:  rnd_up = 1'b0;
      3'b010:  rnd_up = (guard | stk) & s1_sign;
      3'b011:  rnd_up = (guard | stk) & ~s1_sign;
      3'b100:  rnd_up = guard;
      default: rnd_up = guard & (stk | frac[0]);
    endcase
  end

  // Rounding on {exponent, fraction} lets a mantissa carry step the exponent field directly.
  assign exp_pre = hidden ? s1_e : '0;
  assign ext     = {exp_pre, frac} + {{(EW+PARM_MANT-1){1'b0}}, rnd_up};
  assign exp_fin = ext[EW+PARM_MANT-1:PARM_MANT];
  assign ovf     = exp_fin >= EW'(EMAX);
  assign nx      = guard | stk;
  assign uf      = nx & subn & (exp_fin == '0);

  always_comb begin
    case (s1_rnd)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = s1_sign;
      3'b011:  to_inf = ~s1_sign;
      default: to_inf = 1'b1;
    endcase
  end

  always_comb begin
    res_d = {s1_sign, exp_fin[PARM_EXP-1:0], ext[PARM_MANT-1:0]};
    flg_d = {3'b000, uf, nx};
    if (s1_special) begin
      res_d = s1_spec_res;
      flg_d = {s1_invalid, 4'b0000};
    end else if (ovf) begin
      res_d = to_inf ? {s1_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}}
                     : {s1_sign, {(PARM_EXP-1){1'b1}}, 1'b0, {PARM_MANT{1'b1}}};
      flg_d = 5'b00101;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      Valid_o  <= 1'b0;
      Result_o <= '0;
      Fflags_o <= '0;
    end else if (adv) begin
      Valid_o <= s1_valid;
      if (s1_valid) begin
        Result_o <= res_d;
        Fflags_o <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fma_norm_round.sv
`timescale 1ns/1ps
// Bench for fma_norm_round: directed vectors with fixed answers, then random traffic with
// random backpressure checked against an integer quantum-and-round model through a scoreboard.
module tb_fma_norm_round;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        Valid_i, Ready_o, Sign_i, Sticky_i, Special_i, Invalid_i, Valid_o, Ready_i;
  logic [75:0] Sum_i;
  logic [9:0]  Exp_i;
  logic [2:0]  Rnd_mode_i;
  logic [31:0] Special_result_i, Result_o;
  logic [4:0]  Fflags_o;

  int compared = 0;
  int mismatched = 0;
  logic [36:0] sb[$];
  logic [36:0] pend_exp;

  fma_norm_round dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .Sum_i(Sum_i), .Exp_i(Exp_i), .Sign_i(Sign_i), .Sticky_i(Sticky_i),
    .Rnd_mode_i(Rnd_mode_i), .Special_i(Special_i), .Special_result_i(Special_result_i),
    .Invalid_i(Invalid_i), .Valid_o(Valid_o), .Ready_i(Ready_i),
    .Result_o(Result_o), .Fflags_o(Fflags_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic round_up(input logic [2:0] rm, input logic sg, input logic g,
                                    input logic st, input logic lsb);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return (g | st) & sg;
      3'd3:    return (g | st) & !sg;
      3'd4:    return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  function automatic logic [31:0] ovf_value(input logic [2:0] rm, input logic sg);
    logic inf;
    inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sg : (rm == 3'd3) ? !sg : 1'b1;
    return inf ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
  endfunction

  // Result as an integer count of the final quantum: the quantum is 2^-23 of the leading one
  // for normal values and the fixed subnormal step otherwise; the packed magnitude is then
  // (biased exponent - 1) * 2^23 + rounded count.
  function automatic logic [36:0] ref_model(input logic [75:0] sum, input logic signed [9:0] ex,
                                            input logic sg, input logic stk_in, input logic [2:0] rm,
                                            input logic spec, input logic [31:0] spec_res,
                                            input logic inv);
    logic [127:0] s, m, mag, lowm;
    int p, be, q;
    logic g, st, up, nx, uf;
    if (spec) return {spec_res, inv, 4'b0000};
    if (sum == '0) begin
      up = round_up(rm, sg, 1'b0, stk_in, 1'b0);
      return {sg, 30'd0, up, 3'b000, stk_in, stk_in};
    end
    s = {52'd0, sum};
    p = 0;
    for (int i = 0; i < 76; i++) if (sum[i]) p = i;
    be = p - 74 + int'(ex);
    if (be >= 255) return {ovf_value(rm, sg), 5'b00101};
    q = (be >= 1) ? p - 23 : 52 - int'(ex);
    g = 1'b0;
    st = stk_in;
    if (q >= 0) begin
      m = (q >= 128) ? '0 : s >> q;
      if (q >= 1 && q <= 128) g = s[q-1];
      if (q >= 2) begin
        lowm = (q - 1 >= 128) ? '1 : ((128'd1 << (q - 1)) - 128'd1);
        st = st | (|(s & lowm));
      end
    end else begin
      m = s << (-q);
    end
    up = round_up(rm, sg, g, st, m[0]);
    m = m + 128'(up);
    mag = (be >= 1) ? ((128'(be - 1) << 23) + m) : m;
    nx = g | st;
    if (mag >= (128'd255 << 23)) return {ovf_value(rm, sg), 5'b00101};
    uf = nx && (be <= 0) && (mag < (128'd1 << 23));
    return {sg, mag[30:0], 3'b000, uf, nx};
  endfunction

  // One clock: at the falling edge retire an output if it transfers, log an accepted input.
  task automatic cycle(output logic acc);
    logic [36:0] e;
    @(negedge clk_i);
    if (Valid_o && Ready_i) begin
      check("output_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", 64'({Result_o, Fflags_o}), 64'(e));
      end
    end
    acc = Valid_i && Ready_o;
    if (acc) sb.push_back(pend_exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic [75:0] sum, input logic [9:0] ex, input logic sg,
                        input logic st, input logic [2:0] rm);
    Sum_i = sum; Exp_i = ex; Sign_i = sg; Sticky_i = st; Rnd_mode_i = rm;
    Special_i = 1'b0; Special_result_i = '0; Invalid_i = 1'b0;
  endtask

  task automatic send(input logic [36:0] expv);
    logic acc;
    int n;
    pend_exp = expv;
    Valid_i = 1'b1;
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 50);
    check("accept", 64'(acc), 64'd1);
    Valid_i = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    Ready_i = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      cycle(acc);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic rand_op();
    int p, be, j;
    logic [95:0] rb;
    logic [75:0] low, sum;
    logic [9:0] ex;
    p = int'($urandom_range(0, 79));
    if (p >= 76) begin
      sum = '0;
      ex = 10'($urandom);
    end else begin
      rb = {$urandom, $urandom, $urandom};
      low = rb[75:0] & ((76'd1 << p) - 76'd1);
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(0, p));
        low = low & ~((76'd1 << j) - 76'd1);
      end
      sum = (76'd1 << p) | low;
      case ($urandom_range(0, 3))
        0:       be = int'($urandom_range(1, 254));
        1:       be = 250 + int'($urandom_range(0, 12));
        2:       be = 0 - int'($urandom_range(0, 30));
        default: be = -20 - int'($urandom_range(0, 60));
      endcase
      ex = 10'(be + 74 - p);
    end
    set_op(sum, ex, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
    Special_i = ($urandom_range(0, 15) == 0);
    Special_result_i = $urandom;
    Invalid_i = 1'($urandom);
    pend_exp = ref_model(Sum_i, Exp_i, Sign_i, Sticky_i, Rnd_mode_i, Special_i,
                         Special_result_i, Invalid_i);
  endtask

  typedef struct {
    logic [75:0] sum;
    logic [9:0]  ex;
    logic        sg;
    logic        st;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t dv[9];
  logic acc;
  logic [36:0] op_a, op_b, op_c;

  initial begin
    dv[0] = '{76'd1 << 74, 10'd127, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00000};
    dv[1] = '{(76'd1 << 74) | (76'd1 << 50), 10'd127, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00001};
    dv[2] = '{(76'd1 << 74) | (76'd1 << 50), 10'd127, 1'b0, 1'b0, 3'd3, 32'h3F800001, 5'b00001};
    dv[3] = '{(76'd1 << 74) | (76'd1 << 50), 10'd127, 1'b0, 1'b0, 3'd4, 32'h3F800001, 5'b00001};
    dv[4] = '{76'd1 << 74, 10'd300, 1'b0, 1'b0, 3'd0, 32'h7F800000, 5'b00101};
    dv[5] = '{76'd1 << 74, 10'd300, 1'b0, 1'b0, 3'd1, 32'h7F7FFFFF, 5'b00101};
    dv[6] = '{76'd1 << 74, 10'd300, 1'b1, 1'b0, 3'd3, 32'hFF7FFFFF, 5'b00101};
    dv[7] = '{76'd1 << 74, 10'h3FF, 1'b0, 1'b0, 3'd0, 32'h00200000, 5'b00000};
    dv[8] = '{76'd1 << 74, 10'h3FF, 1'b0, 1'b1, 3'd0, 32'h00200000, 5'b00011};

    rst_ni = 1'b1;
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    set_op('0, '0, 1'b0, 1'b0, 3'd0);
    acc = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("reset_valid", 64'(Valid_o), 64'd0);
    check("reset_result", 64'(Result_o), 64'd0);
    check("reset_flags", 64'(Fflags_o), 64'd0);
    check("reset_ready", 64'(Ready_o), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Latency: accepted at one edge, visible after the next.
    set_op(dv[0].sum, dv[0].ex, dv[0].sg, dv[0].st, dv[0].rm);
    pend_exp = {dv[0].res, dv[0].fl};
    Valid_i = 1'b1;
    cycle(acc);
    check("lat_accept", 64'(acc), 64'd1);
    Valid_i = 1'b0;
    check("lat_stage1", 64'(Valid_o), 64'd0);
    cycle(acc);
    check("lat_out", 64'(Valid_o), 64'd1);
    drain();

    for (int i = 0; i < 9; i++) begin
      set_op(dv[i].sum, dv[i].ex, dv[i].sg, dv[i].st, dv[i].rm);
      send({dv[i].res, dv[i].fl});
    end
    drain();

    set_op(76'd12345, 10'd5, 1'b0, 1'b0, 3'd0);
    Special_i = 1'b1;
    Special_result_i = 32'h7FC00000;
    Invalid_i = 1'b1;
    send({32'h7FC00000, 5'b10000});
    drain();

    // Backpressure: A and B fill the pipe, C waits until the sink frees it.
    op_a = {dv[0].res, dv[0].fl};
    op_b = {dv[2].res, dv[2].fl};
    op_c = {dv[4].res, dv[4].fl};
    Ready_i = 1'b0;
    set_op(dv[0].sum, dv[0].ex, dv[0].sg, dv[0].st, dv[0].rm);
    pend_exp = op_a;
    Valid_i = 1'b1;
    cycle(acc);
    check("bp_accept_a", 64'(acc), 64'd1);
    set_op(dv[2].sum, dv[2].ex, dv[2].sg, dv[2].st, dv[2].rm);
    pend_exp = op_b;
    cycle(acc);
    check("bp_accept_b", 64'(acc), 64'd1);
    set_op(dv[4].sum, dv[4].ex, dv[4].sg, dv[4].st, dv[4].rm);
    pend_exp = op_c;
    check("bp_ready_low", 64'(Ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 64'(Valid_o), 64'd1);
      check("bp_hold_a", 64'({Result_o, Fflags_o}), 64'(op_a));
      cycle(acc);
      check("bp_no_accept", 64'(acc), 64'd0);
    end
    Ready_i = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        cycle(acc);
        n++;
      end while (!acc && n < 20);
    end
    check("bp_accept_c", 64'(acc), 64'd1);
    Valid_i = 1'b0;
    drain();

    // Asynchronous reset drops a held result between clock edges.
    Ready_i = 1'b0;
    set_op(dv[2].sum, dv[2].ex, dv[2].sg, dv[2].st, dv[2].rm);
    send({dv[2].res, dv[2].fl});
    cycle(acc);
    check("rst_pre_valid", 64'(Valid_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_valid", 64'(Valid_o), 64'd0);
    check("rst_async_result", 64'(Result_o), 64'd0);
    check("rst_async_flags", 64'(Fflags_o), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_release_ready", 64'(Ready_o), 64'd1);
    check("rst_release_valid", 64'(Valid_o), 64'd0);
    Ready_i = 1'b1;

    acc = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (!Valid_i || acc) begin
        rand_op();
        Valid_i = ($urandom_range(0, 3) != 0);
      end
      Ready_i = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    Valid_i = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
